// File: rtl/bitblade_column_ctrl_if.sv
// Bundle of the column controller's job-request and control-output signals.
//
// Ports (as interface signals):
//   start, cfg_bitwidth, cfg_signed_x, cfg_signed_y, num_vectors : job request
//   state, signal, sign_x, sign_y, input_bitwidth                : column config
//   wbuf_load, ibuf_rd, acc_clear                                : datapath strobes
//   busy, done                                                   : job status
//   fsm_dbg                                                      : raw FSM state
//
// Handshake: a job is requested by holding start=1 across a rising edge while
// busy=0 (controller in IDLE). The controller raises busy the cycle after
// acceptance, keeps it high for the whole job, pulses done for exactly one
// cycle at the end, and ignores start (no queueing) while busy=1.
interface bitblade_column_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       cfg_bitwidth;
  logic             cfg_signed_x;
  logic             cfg_signed_y;
  logic [CNT_W-1:0] num_vectors;

  logic [1:0]       state;
  logic [47:0]      signal;
  logic [3:0]       sign_x;
  logic [3:0]       sign_y;
  logic [1:0]       input_bitwidth;
  logic             wbuf_load;
  logic             ibuf_rd;
  logic             acc_clear;
  logic             busy;
  logic             done;
  logic [2:0]       fsm_dbg;

  modport master (
    output start, cfg_bitwidth, cfg_signed_x, cfg_signed_y, num_vectors,
    input  state, signal, sign_x, sign_y, input_bitwidth,
    input  wbuf_load, ibuf_rd, acc_clear, busy, done, fsm_dbg
  );

  modport slave (
    input  start, cfg_bitwidth, cfg_signed_x, cfg_signed_y, num_vectors,
    output state, signal, sign_x, sign_y, input_bitwidth,
    output wbuf_load, ibuf_rd, acc_clear, busy, done, fsm_dbg
  );
endinterface

// File: rtl/bitblade_column_ctrl.sv
// BitBlade column controller: sequences one column job
// (IDLE -> LOAD -> COMPUTE -> DRAIN -> DONE -> IDLE) and drives the per-PE
// shift codes and sign enables for the selected operand precision.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; aborts any job, clears all outputs
//   bus    : bitblade_column_ctrl_if.slave (request in, config/strobes out)
//
// Parameters:
//   CNT_W        : width of num_vectors
//   DRAIN_CYCLES : column pipeline drain length (1..15)
module bitblade_column_ctrl #(
  parameter int CNT_W        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bitblade_column_ctrl_if.slave bus
);

  // Counter is at least 4 bits so a 15-cycle drain always fits.
  localparam int CW = (CNT_W > 4) ? CNT_W : 4;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;
  logic [1:0]    code_d;

  logic [1:0]    bw_norm;
  logic [47:0]   sig_d;
  logic [3:0]    sx_d, sy_d;

  assign bus.fsm_dbg = state_q;

  // Next-state logic. cnt_q holds "remaining cycles in this phase minus one";
  // during LOAD it holds the latched vector count N itself.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_LOAD;
          cnt_d   = CW'(bus.num_vectors);
        end
      end
      S_LOAD: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LAST;
        end else begin
          state_d = S_COMPUTE;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // External state code merges DRAIN and DONE.
  always_comb begin
    code_d = 2'b00;
    case (state_d)
      S_IDLE:    code_d = 2'b00;
      S_LOAD:    code_d = 2'b01;
      S_COMPUTE: code_d = 2'b10;
      S_DRAIN:   code_d = 2'b11;
      S_DONE:    code_d = 2'b11;
      default:   code_d = 2'b00;
    endcase
  end

  // Per-PE configuration from the request inputs. 2'b11 is folded into 8b so
  // every downstream consumer (including the weight MUX) sees one encoding.
  // PE i sits at row r=i/4, column c=i%4; its partial product is shifted by
  // 2k bits where k is the sum of the 2-bit chunk positions of r and c.
  always_comb begin
    logic [1:0] r;
    logic [1:0] c;
    logic [2:0] k;
    logic       msb;
    bw_norm = (bus.cfg_bitwidth == 2'b11) ? 2'b10 : bus.cfg_bitwidth;
    sig_d   = '0;
    sx_d    = '0;
    sy_d    = '0;
    r       = '0;
    c       = '0;
    k       = '0;
    msb     = 1'b0;
    for (int i = 0; i < 16; i++) begin
      r = i[3:2];
      c = i[1:0];
      case (bw_norm)
        2'b10:   k = {1'b0, r} + {1'b0, c};
        2'b01:   k = {2'b00, r[0]} + {2'b00, c[0]};
        default: k = 3'd0;
      endcase
      sig_d[3*i +: 3] = k;
    end
    // Sign extension applies only to the chunk holding the operand MSB.
    for (int j = 0; j < 4; j++) begin
      case (bw_norm)
        2'b10:   msb = (j == 3);
        2'b01:   msb = j[0];
        default: msb = 1'b1;
      endcase
      sx_d[j] = bus.cfg_signed_x & msb;
      sy_d[j] = bus.cfg_signed_y & msb;
    end
  end

  // State register plus registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      bus.state          <= 2'b00;
      bus.signal         <= '0;
      bus.sign_x         <= '0;
      bus.sign_y         <= '0;
      bus.input_bitwidth <= 2'b00;
      bus.wbuf_load      <= 1'b0;
      bus.ibuf_rd        <= 1'b0;
      bus.acc_clear      <= 1'b0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus.state     <= code_d;
      bus.wbuf_load <= (state_d == S_LOAD);
      bus.acc_clear <= (state_d == S_LOAD);
      bus.ibuf_rd   <= (state_d == S_COMPUTE);
      bus.busy      <= (state_d != S_IDLE);
      bus.done      <= (state_d == S_DONE);
      // Configuration is captured only at acceptance and then held through
      // DONE and the following IDLE period.
      if (accept) begin
        bus.signal         <= sig_d;
        bus.sign_x         <= sx_d;
        bus.sign_y         <= sy_d;
        bus.input_bitwidth <= bw_norm;
      end
    end
  end

endmodule

// File: tb/tb_bitblade_column_ctrl.sv
module tb_bitblade_column_ctrl;

  localparam int CNT_W = 8;
  localparam int DRAIN = 4;

  // Hand-computed shift-code maps, PE15 first down to PE0.
  localparam logic [47:0] SIG8 = {3'd6, 3'd5, 3'd4, 3'd3, 3'd5, 3'd4, 3'd3, 3'd2,
                                  3'd4, 3'd3, 3'd2, 3'd1, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [47:0] SIG4 = {3'd2, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0,
                                  3'd2, 3'd1, 3'd2, 3'd1, 3'd1, 3'd0, 3'd1, 3'd0};

  typedef struct {
    logic [1:0]  bw;
    logic        sx;
    logic        sy;
    logic [7:0]  n;
    logic [47:0] exp_sig;
    logic [3:0]  exp_sx;
    logic [3:0]  exp_sy;
    logic [1:0]  exp_ibw;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bitblade_column_ctrl_if #(.CNT_W(CNT_W)) bus ();

  bitblade_column_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] exp_q[$];
  vec_t vecs[8];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [64:0] all_outs();
    return {bus.state, bus.signal, bus.sign_x, bus.sign_y, bus.input_bitwidth,
            bus.wbuf_load, bus.ibuf_rd, bus.acc_clear, bus.busy, bus.done};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; requests a job and monitors it to its end, which is
  // the first negedge with busy=0 (the mandatory IDLE cycle).
  task automatic run_job(input vec_t v, input bit scramble, input string tag);
    int busy_c, ibuf_c, load_c, drain_c, done_c, seq_err, cfg_err, cyc;
    bit finished;
    busy_c = 0; ibuf_c = 0; load_c = 0; drain_c = 0; done_c = 0;
    seq_err = 0; cfg_err = 0; cyc = 0; finished = 0;
    bus.cfg_bitwidth = v.bw;
    bus.cfg_signed_x = v.sx;
    bus.cfg_signed_y = v.sy;
    bus.num_vectors  = v.n;
    bus.start        = 1'b1;
    exp_q.push_back(16'(2 + int'(v.n) + DRAIN));
    exp_q.push_back(16'(v.n));
    exp_q.push_back(16'd1);
    exp_q.push_back(16'(DRAIN));
    exp_q.push_back(16'd1);
    @(posedge clk);
    if (!scramble) begin
      #1 bus.start = 1'b0;
    end
    while (!finished && cyc < 2 + int'(v.n) + DRAIN + 10) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) begin
        busy_c++;
        if (bus.ibuf_rd) ibuf_c++;
        if (bus.state == 2'b01) load_c++;
        if (bus.state == 2'b11 && !bus.done) drain_c++;
        if (bus.done) done_c++;
        if (cyc == 1 && bus.state != 2'b01) seq_err++;
        if (bus.ibuf_rd && bus.state != 2'b10) seq_err++;
        if (bus.wbuf_load != (bus.state == 2'b01)) seq_err++;
        if (bus.acc_clear != bus.wbuf_load) seq_err++;
        if (bus.done && bus.state != 2'b11) seq_err++;
        if (bus.signal != v.exp_sig || bus.sign_x != v.exp_sx ||
            bus.sign_y != v.exp_sy || bus.input_bitwidth != v.exp_ibw) cfg_err++;
        if (scramble) begin
          bus.start        = (cyc < 4) ? 1'b1 : 1'($urandom_range(0, 1));
          bus.num_vectors  = 8'($urandom_range(0, 255));
          bus.cfg_bitwidth = 2'($urandom_range(0, 3));
          bus.cfg_signed_x = ~v.sx;
          bus.cfg_signed_y = ~v.sy;
        end
      end else begin
        finished  = 1;
        bus.start = 1'b0;
      end
    end
    check({tag, "_timeout"}, 96'(finished), 96'd1);
    check({tag, "_busy_len"}, 96'(busy_c), 96'(exp_q.pop_front()));
    check({tag, "_ibuf_rd"}, 96'(ibuf_c), 96'(exp_q.pop_front()));
    check({tag, "_load"}, 96'(load_c), 96'(exp_q.pop_front()));
    check({tag, "_drain"}, 96'(drain_c), 96'(exp_q.pop_front()));
    check({tag, "_done"}, 96'(done_c), 96'(exp_q.pop_front()));
    check({tag, "_seq"}, 96'(seq_err), 96'd0);
    check({tag, "_cfg_busy"}, 96'(cfg_err), 96'd0);
    check({tag, "_cfg_idle"},
          96'({bus.signal, bus.sign_x, bus.sign_y, bus.input_bitwidth, bus.state}),
          96'({v.exp_sig, v.exp_sx, v.exp_sy, v.exp_ibw, 2'b00}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idle_busy, done_seen;
    vec_t sv;

    vecs[0] = '{2'b10, 1'b1, 1'b1, 8'd3,   SIG8,  4'b1000, 4'b1000, 2'b10};
    vecs[1] = '{2'b01, 1'b1, 1'b0, 8'd2,   SIG4,  4'b1010, 4'b0000, 2'b01};
    vecs[2] = '{2'b00, 1'b1, 1'b1, 8'd1,   48'd0, 4'b1111, 4'b1111, 2'b00};
    vecs[3] = '{2'b00, 1'b0, 1'b1, 8'd5,   48'd0, 4'b0000, 4'b1111, 2'b00};
    vecs[4] = '{2'b11, 1'b1, 1'b1, 8'd3,   SIG8,  4'b1000, 4'b1000, 2'b10};
    vecs[5] = '{2'b10, 1'b0, 1'b0, 8'd0,   SIG8,  4'b0000, 4'b0000, 2'b10};
    vecs[6] = '{2'b01, 1'b0, 1'b1, 8'd4,   SIG4,  4'b0000, 4'b1010, 2'b01};
    vecs[7] = '{2'b10, 1'b0, 1'b1, 8'd255, SIG8,  4'b0000, 4'b1000, 2'b10};

    bus.start = 1'b0;
    bus.cfg_bitwidth = 2'b10;
    bus.cfg_signed_x = 1'b1;
    bus.cfg_signed_y = 1'b1;
    bus.num_vectors = 8'd7;
    reset = 1'b1;
    #1;
    check("reset_async", 96'(all_outs()), 96'd0);
    repeat (3) @(negedge clk);
    check("reset_held", 96'(all_outs()), 96'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 96'(all_outs()), 96'd0);

    // Table loop; jobs run back-to-back with the single mandatory IDLE cycle.
    for (int i = 0; i < 8; i++) begin
      run_job(vecs[i], 1'b0, $sformatf("vec%0d", i));
      if (i == 0) begin
        check("pe5_8b",  96'(bus.signal[15 +: 3]), 96'd2);
        check("pe15_8b", 96'(bus.signal[45 +: 3]), 96'd6);
        check("pe0_8b",  96'(bus.signal[0 +: 3]),  96'd0);
      end
      if (i == 1) begin
        check("pe15_4b", 96'(bus.signal[45 +: 3]), 96'd2);
        check("pe6_4b",  96'(bus.signal[18 +: 3]), 96'd1);
      end
    end

    // Start held/toggled and inputs churned while busy: one job, original N.
    sv = '{2'b10, 1'b1, 1'b0, 8'd6, SIG8, 4'b1000, 4'b0000, 2'b10};
    run_job(sv, 1'b1, "scramble");
    idle_busy = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.busy) idle_busy++;
    end
    check("scramble_no_requeue", 96'(idle_busy), 96'd0);

    // Asynchronous reset in the second COMPUTE cycle.
    bus.cfg_bitwidth = 2'b10;
    bus.cfg_signed_x = 1'b1;
    bus.cfg_signed_y = 1'b1;
    bus.num_vectors  = 8'd5;
    bus.start        = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check("rst_seq_load", 96'(bus.state), 96'(2'b01));
    @(negedge clk);
    @(negedge clk);
    check("rst_seq_compute2", 96'({bus.state, bus.ibuf_rd}), 96'({2'b10, 1'b1}));
    #2 reset = 1'b1;
    #1;
    check("rst_mid_outs", 96'(all_outs()), 96'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("rst_no_done_no_restart", 96'(done_seen), 96'd0);
    run_job(vecs[0], 1'b0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitblade_column_ctrl.md
BITBLADE_COLUMN_CTRL -- requirements
Module: bitblade_column_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of vector count.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, column pipeline drain length in cycles (valid range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to run one column job; sampled only in IDLE.
REQ-006 SHALL have port cfg_bitwidth  input  2  operand precision: 00=2b, 01=4b, 10=8b, 11 treated as 8b.
REQ-007 SHALL have port cfg_signed_x  input  1  input activations are signed.
REQ-008 SHALL have port cfg_signed_y  input  1  weights are signed.
REQ-009 SHALL have port num_vectors  input  CNT_W  number of input vectors to accumulate.
REQ-010 SHALL have port state  output  2  column state code: IDLE=00, LOAD=01, COMPUTE=10, DRAIN/DONE=11.
REQ-011 SHALL have port signal  output  48  per-PE shift code, 3 bits per PE i at [3i+2:3i].
REQ-012 SHALL have port sign_x  output  4  per-PE-row input sign enables.
REQ-013 SHALL have port sign_y  output  4  per-PE-column weight sign enables.
REQ-014 SHALL have port input_bitwidth  output  2  latched cfg_bitwidth driven to the weight MUX registers.
REQ-015 SHALL have port wbuf_load  output  1  weight buffer load strobe.
REQ-016 SHALL have port ibuf_rd  output  1  input buffer read strobe, one vector per cycle.
REQ-017 SHALL have port acc_clear  output  1  accumulator clear strobe.
REQ-018 SHALL have ports busy, done  output  1 each  job in progress / one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM IDLE->LOAD->COMPUTE->DRAIN->DONE->IDLE; all outputs registered.
REQ-020 SHALL leave IDLE only when start=1 at a clock edge; start in any other state is ignored, not queued.
REQ-021 SHALL latch cfg_bitwidth, cfg_signed_x, cfg_signed_y, num_vectors on start acceptance; later input changes have no effect until next acceptance.
REQ-022 SHALL spend exactly 1 cycle in LOAD with wbuf_load=1 and acc_clear=1.
REQ-023 SHALL spend exactly N=latched num_vectors cycles in COMPUTE with ibuf_rd=1 each cycle; N=0 goes LOAD->DRAIN directly, ibuf_rd never asserted.
REQ-024 SHALL spend exactly DRAIN_CYCLES cycles in DRAIN, then 1 cycle in DONE with done=1.
REQ-025 SHALL hold busy=1 in LOAD, COMPUTE, DRAIN, DONE; total busy length = 2+N+DRAIN_CYCLES cycles.
REQ-026 SHALL compute, for PE i (r=i/4, c=i%4): k = r+c for 8b; (r%2)+(c%2) for 4b; 0 for 2b; signal[3i+2:3i]=k (shift of 2k bits).
REQ-027 SHALL set sign_x[r]=cfg_signed_x AND r is MSB chunk row: r==3 for 8b, r odd for 4b, every r for 2b; sign_y[c] likewise with cfg_signed_y.
REQ-028 SHALL update signal, sign_x, sign_y, input_bitwidth on entry to LOAD and hold them constant through DONE and subsequent IDLE.
REQ-029 SHALL allow start accepted in the cycle after DONE (back-to-back jobs, one IDLE cycle minimum).
REQ-030 SHALL use a counter of width max(CNT_W,4) with no wrap: N=2^CNT_W-1 yields exactly that many COMPUTE cycles.

Reset
REQ-031 SHALL on reset asynchronously force FSM to IDLE and all outputs to 0 (state=00, signal=0, sign_x=sign_y=0, input_bitwidth=00, strobes/busy/done=0), counters cleared.
REQ-032 SHALL on reset mid-job abort immediately; no done pulse produced; next job requires new start after reset release.

Verification
REQ-033 Bench SHALL check: cfg 8b, signed_x=signed_y=1, N=3, start 1 cycle -> LOAD 1 cycle (wbuf_load, acc_clear), ibuf_rd 3 cycles, DRAIN 4, done 1 cycle; busy 9 cycles; sign_x=sign_y=4'b1000; signal PE5=2, PE15=6, PE0=0.
REQ-034 Bench SHALL check: cfg 4b, signed_x=1, signed_y=0 -> sign_x=4'b1010, sign_y=0000, signal PE15=2, PE6=1; cfg 2b -> signal=0, sign_x=1111 if signed.
REQ-035 Bench SHALL check: N=0 -> no ibuf_rd, busy 6 cycles, done pulse present.
REQ-036 Bench SHALL check: start held high and toggled while busy, num_vectors changed mid-job -> single job, original N honoured; new job starts only from IDLE.
REQ-037 Bench SHALL check: reset asserted asynchronously in COMPUTE cycle 2 -> all outputs 0 before next edge, no done; fresh start after release runs a full job.
REQ-038 Bench SHALL check: cfg_bitwidth=11 -> outputs identical to 8b; N=255 -> exactly 255 ibuf_rd cycles.
